f32_round_pack: RTL and testbench

F32_ROUND_PACK -- requirements
Module: f32_round_pack

---
 rtl/f32_pkg.sv | 31 +++
 rtl/lzc48.sv | 20 ++
 rtl/f32_round_pack.sv | 169 ++++++++++++++++
 tb/tb_f32_round_pack.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/f32_pkg.sv
// rtl/f32_pkg.sv - shared binary32 constants, class/flag indices and stage record
package f32_pkg;

  localparam int          F32_BIAS    = 127;
  localparam int          F32_EXP_MAX = 255;
  localparam logic [31:0] F32_QNAN    = 32'h7FC0_0000;

  // in_class = {nan, inf, zero}
  localparam int CLS_NAN  = 2;
  localparam int CLS_INF  = 1;
  localparam int CLS_ZERO = 0;

  // out_flags = {overflow, underflow, inexact}
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] sig;
    logic        guard;
    logic        sticky;
    logic [2:0]  cls;
  } s1_rec_t;

  function automatic logic [31:0] f32_inf(input logic sign);
    return {sign, 8'hFF, 23'd0};
  endfunction

endpackage

// File: rtl/lzc48.sv
// rtl/lzc48.sv - leading-zero count of a 47-bit field (47 when all zero)
module lzc48 (
  input  logic [46:0] data,
  output logic [5:0]  count
);

  logic found;

  always_comb begin
    count = 6'd47;
    found = 1'b0;
    for (int i = 46; i >= 0; i--) begin
      if (!found && data[i]) begin
        count = 6'(46 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/f32_round_pack.sv
// rtl/f32_round_pack.sv - two-stage normalise / round / pack for the binary32 multiplier
module f32_round_pack
  import f32_pkg::*;
#(
  parameter bit RNE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [47:0] in_prod,
  input  logic [2:0]  in_class,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_flags
);

  logic    s1_valid;
  s1_rec_t s1_q;
  s1_rec_t s1_d;
  logic    s2_load;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  // ---------------- stage 1: normalise ----------------
  logic [5:0]         lz;
  logic [5:0]         lsh;
  logic [4:0]         rsh;
  logic signed [11:0] e0;
  logic signed [11:0] e1;
  logic signed [11:0] room;
  logic signed [11:0] lz_ext;
  logic signed [11:0] one_minus;
  logic [46:0]        m0;
  logic [46:0]        m1;
  logic [46:0]        mask;
  logic               drop0;
  logic               drop1;

  lzc48 u_lzc (
    .data  (in_prod[46:0]),
    .count (lz)
  );

  always_comb begin
    e0        = {{2{in_exp[9]}}, in_exp};
    m0        = in_prod[46:0];
    drop0     = 1'b0;
    lsh       = 6'd0;
    rsh       = 5'd0;
    room      = e0 - 12'sd1;
    lz_ext    = $signed({6'd0, lz});
    one_minus = 12'sd0;
    mask      = 47'd0;
    drop1     = 1'b0;
    e1        = 12'sd0;
    m1        = 47'd0;
    s1_d      = '0;

    if (in_prod[47]) begin
      m0    = in_prod[47:1];
      drop0 = in_prod[0];
      e0    = e0 + 12'sd1;
    end else if (!in_prod[46]) begin
      // left shift never takes the exponent below 1
      if (e0 <= 12'sd1)
        lsh = 6'd0;
      else if (lz_ext > room)
        lsh = room[5:0];
      else
        lsh = lz;
      m0 = in_prod[46:0] << lsh;
      e0 = e0 - $signed({6'd0, lsh});
    end

    one_minus = 12'sd1 - e0;
    if (e0 <= 12'sd0) begin
      rsh   = (one_minus > 12'sd26) ? 5'd26 : one_minus[4:0];
      mask  = (47'd1 << rsh) - 47'd1;
      drop1 = |(m0 & mask);
      m1    = m0 >> rsh;
      e1    = 12'sd0;
    end else begin
      m1 = m0;
      // a stalled left shift at exp 1 leaves no hidden bit: encode as subnormal
      e1 = m0[46] ? e0 : 12'sd0;
    end

    s1_d.sign   = in_sign;
    s1_d.exp    = (e1 > 12'sd255) ? 10'd255 : e1[9:0];
    s1_d.sig    = m1[46:23];
    s1_d.guard  = m1[22];
    s1_d.sticky = (|m1[21:0]) | drop0 | drop1;
    s1_d.cls    = in_class;
    s1_d.cls[CLS_ZERO] = in_class[CLS_ZERO] | ~|in_prod;
  end

  // ---------------- stage 2: round, specials, pack ----------------
  logic        inc;
  logic [24:0] sum;
  logic [9:0]  ef;
  logic [22:0] frac;
  logic        inexact;
  logic [31:0] pk_data;
  logic [2:0]  pk_flags;

  always_comb begin
    inc      = RNE && s1_q.guard && (s1_q.sticky || s1_q.sig[0]);
    sum      = {1'b0, s1_q.sig} + {24'd0, inc};
    inexact  = s1_q.guard || s1_q.sticky;
    ef       = s1_q.exp;
    frac     = sum[22:0];
    pk_data  = 32'd0;
    pk_flags = 3'd0;

    if (sum[24]) begin
      ef   = s1_q.exp + 10'd1;
      frac = sum[23:1];
    end else if (s1_q.exp == 10'd0 && sum[23]) begin
      ef = 10'd1;
    end

    if (s1_q.cls[CLS_NAN] || (s1_q.cls[CLS_INF] && s1_q.cls[CLS_ZERO])) begin
      pk_data = F32_QNAN;
    end else if (s1_q.cls[CLS_INF]) begin
      pk_data = f32_inf(s1_q.sign);
    end else if (s1_q.cls[CLS_ZERO]) begin
      pk_data = {s1_q.sign, 31'd0};
    end else if (ef >= 10'(F32_EXP_MAX)) begin
      pk_data           = f32_inf(s1_q.sign);
      pk_flags[FLG_OVF] = 1'b1;
      pk_flags[FLG_INX] = 1'b1;
    end else begin
      pk_data           = {s1_q.sign, ef[7:0], frac};
      pk_flags[FLG_UNF] = (ef == 10'd0) && inexact;
      pk_flags[FLG_INX] = inexact;
    end
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_flags <= 3'd0;
    end else begin
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data  <= pk_data;
          out_flags <= pk_flags;
        end
      end
      if (in_ready)
        s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready)
      s1_q <= s1_d;
  end

endmodule

// File: tb/tb_f32_round_pack.sv
// tb/tb_f32_round_pack.sv - scoreboard bench for f32_round_pack (RNE and truncating instances)
module tb_f32_round_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_prod;
  logic [2:0]  in_class;
  logic        out_ready;

  logic        in_ready,  in_ready_t;
  logic        out_valid, out_valid_t;
  logic [31:0] out_data,  out_data_t;
  logic [2:0]  out_flags, out_flags_t;

  always #5 clk = ~clk;

  f32_round_pack #(.RNE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_prod(in_prod), .in_class(in_class),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags)
  );

  f32_round_pack #(.RNE(1'b0)) dut_trunc (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_t),
    .in_sign(in_sign), .in_exp(in_exp), .in_prod(in_prod), .in_class(in_class),
    .out_valid(out_valid_t), .out_ready(out_ready),
    .out_data(out_data_t), .out_flags(out_flags_t)
  );

  typedef struct {
    logic [31:0] d1;
    logic [2:0]  f1;
    logic [31:0] d0;
    logic [2:0]  f0;
  } exp_t;

  typedef struct {
    logic        sign;
    logic [9:0]  e;
    logic [47:0] prod;
    logic [2:0]  cls;
    exp_t        x;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks   = 0;
  int   errors   = 0;
  int   accepted = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic vec_t mkv(input logic s, input logic [9:0] e, input logic [47:0] p,
                               input logic [2:0] c, input logic [31:0] d1, input logic [2:0] f1,
                               input logic [31:0] d0, input logic [2:0] f0);
    vec_t v;
    v.sign = s; v.e = e; v.prod = p; v.cls = c;
    v.x.d1 = d1; v.x.f1 = f1; v.x.d0 = d0; v.x.f0 = f0;
    return v;
  endfunction

  task automatic send(input vec_t v);
    int   n;
    logic acc;
    in_valid = 1'b1;
    in_sign  = v.sign;
    in_exp   = v.e;
    in_prod  = v.prod;
    in_class = v.cls;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) begin
        sb.push_back(v.x);
        accepted++;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required acceptance", n);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // monitor: pops expected results on each transfer, and checks holding under backpressure
  logic        hold_prev = 1'b0;
  logic [31:0] hold_d;
  logic [2:0]  hold_f;
  exp_t        mx;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && out_valid) begin
        chk("hold_data", out_data, hold_d);
        chk("hold_flags", {29'd0, out_flags}, {29'd0, hold_f});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h, required no output", out_data);
        end else begin
          mx = sb.pop_front();
          chk("data_rne",   out_data, mx.d1);
          chk("flags_rne",  {29'd0, out_flags}, {29'd0, mx.f1});
          chk("valid_trunc", {31'd0, out_valid_t}, 32'd1);
          chk("data_trunc", out_data_t, mx.d0);
          chk("flags_trunc", {29'd0, out_flags_t}, {29'd0, mx.f0});
        end
      end
      hold_prev = out_valid && !out_ready;
      hold_d    = out_data;
      hold_f    = out_flags;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 10'd0;
    in_prod   = 48'd0;
    in_class  = 3'd0;
    out_ready = 1'b1;

    //          sign  exp       prod              class   rne data      f     trunc data    f
    vecs.push_back(mkv(0, 10'd127, 48'h900000000000, 3'b000, 32'h40100000, 3'b000, 32'h40100000, 3'b000));
    vecs.push_back(mkv(0, 10'd127, 48'h400000400000, 3'b000, 32'h3F800000, 3'b001, 32'h3F800000, 3'b001));
    vecs.push_back(mkv(0, 10'd127, 48'h400000C00000, 3'b000, 32'h3F800002, 3'b001, 32'h3F800001, 3'b001));
    vecs.push_back(mkv(0, 10'd254, 48'h800000000000, 3'b000, 32'h7F800000, 3'b101, 32'h7F800000, 3'b101));
    vecs.push_back(mkv(0, 10'd0,   48'h400000000000, 3'b000, 32'h00400000, 3'b000, 32'h00400000, 3'b000));
    vecs.push_back(mkv(0, 10'd127, 48'h400000000000, 3'b011, 32'h7FC00000, 3'b000, 32'h7FC00000, 3'b000));
    vecs.push_back(mkv(1, 10'd127, 48'h400000000000, 3'b100, 32'h7FC00000, 3'b000, 32'h7FC00000, 3'b000));
    vecs.push_back(mkv(1, 10'd127, 48'h400000000000, 3'b010, 32'hFF800000, 3'b000, 32'hFF800000, 3'b000));
    vecs.push_back(mkv(1, 10'd127, 48'h400000000000, 3'b001, 32'h80000000, 3'b000, 32'h80000000, 3'b000));
    vecs.push_back(mkv(1, 10'd127, 48'h000000000000, 3'b000, 32'h80000000, 3'b000, 32'h80000000, 3'b000));
    vecs.push_back(mkv(0, 10'd127, 48'h100000000000, 3'b000, 32'h3E800000, 3'b000, 32'h3E800000, 3'b000));
    vecs.push_back(mkv(0, 10'd2,   48'h100000000000, 3'b000, 32'h00400000, 3'b000, 32'h00400000, 3'b000));
    vecs.push_back(mkv(0, 10'd0,   48'h7FFFFFC00000, 3'b000, 32'h00800000, 3'b001, 32'h007FFFFF, 3'b011));
    vecs.push_back(mkv(0, 10'h3E2, 48'h400000000000, 3'b000, 32'h00000000, 3'b011, 32'h00000000, 3'b011));
    vecs.push_back(mkv(0, 10'd127, 48'h7FFFFFC00000, 3'b000, 32'h40000000, 3'b001, 32'h3FFFFFFF, 3'b001));
    vecs.push_back(mkv(0, 10'd254, 48'h7FFFFFC00000, 3'b000, 32'h7F800000, 3'b101, 32'h7F7FFFFF, 3'b001));
    vecs.push_back(mkv(1, 10'd254, 48'h800000000000, 3'b000, 32'hFF800000, 3'b101, 32'hFF800000, 3'b101));
    vecs.push_back(mkv(1, 10'd127, 48'h900000000000, 3'b000, 32'hC0100000, 3'b000, 32'hC0100000, 3'b000));

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_data",  out_data, 32'd0);
    chk("rst_out_flags", {29'd0, out_flags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // latency
    send(vecs[0]);
    in_valid = 1'b0;
    chk("lat_after_accept", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_one_later", {31'd0, out_valid}, 32'd1);
    drain();

    // back-to-back stream of all vectors
    foreach (vecs[i]) send(vecs[i]);
    in_valid = 1'b0;
    drain();

    // backpressure: 6 stalled cycles with 4 inputs offered
    base      = accepted;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 1; i < 5; i++) send(vecs[i]);
        in_valid = 1'b0;
      end
      begin
        repeat (6) begin
          @(posedge clk);
          #1;
        end
        chk("bp_accepted", accepted - base, 2);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("bp_stream_valid", {31'd0, out_valid}, 32'd1);
        end
      end
    join
    drain();

    // asynchronous reset with both stages full
    out_ready = 1'b0;
    send(vecs[1]);
    send(vecs[2]);
    in_valid = 1'b0;
    chk("full_before_rst", {31'd0, out_valid}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("arst_out_data",  out_data, 32'd0);
    chk("arst_out_flags", {29'd0, out_flags}, 32'd0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    send(vecs[3]);
    in_valid = 1'b0;
    chk("post_rst_lat0", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("post_rst_lat1", {31'd0, out_valid}, 32'd1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
